// File: rtl/gate_sweep_ctrl.sv
// Truth-table sequencer for a 2-input combinational gate.
// Drives {a,b} = 00..11, waits SETTLE_CYCLES per vector, samples y and records mismatches.
module gate_sweep_ctrl #(
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter logic [3:0]  TRUTH         = 4'b0110
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  output logic       gate_a,
  output logic       gate_b,
  input  logic       gate_y,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [2:0] err_count,
  output logic       fail_valid,
  output logic [1:0] first_fail_idx
);

  localparam int unsigned CNT_W = 4;
  localparam int unsigned ERR_W = 3;
  localparam int unsigned IDX_W = 2;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_DRIVE  = 3'd1;
  localparam logic [2:0] S_SETTLE = 3'd2;
  localparam logic [2:0] S_SAMPLE = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  logic [2:0]       r_state;
  logic [2:0]       w_state_nxt;
  logic [IDX_W-1:0] r_idx;
  logic [IDX_W-1:0] w_idx_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [ERR_W-1:0] r_err;
  logic [ERR_W-1:0] w_err_nxt;
  logic             r_fail_valid;
  logic             w_fail_valid_nxt;
  logic [IDX_W-1:0] r_first_fail;
  logic [IDX_W-1:0] w_first_fail_nxt;
  logic             r_pass;
  logic             w_pass_nxt;
  logic             r_busy;
  logic             w_busy_nxt;
  logic             r_done;
  logic             r_gate_a;
  logic             r_gate_b;
  logic             w_mismatch;

  assign w_mismatch = gate_y ^ TRUTH[r_idx];

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state and next datapath values; abort always wins while sweeping
  always_comb begin
    w_state_nxt      = r_state;
    w_idx_nxt        = r_idx;
    w_cnt_nxt        = r_cnt;
    w_err_nxt        = r_err;
    w_fail_valid_nxt = r_fail_valid;
    w_first_fail_nxt = r_first_fail;
    w_pass_nxt       = r_pass;
    case (r_state)
      S_IDLE: begin
        if (start && !abort) begin
          w_state_nxt      = S_DRIVE;
          w_idx_nxt        = '0;
          w_err_nxt        = '0;
          w_fail_valid_nxt = 1'b0;
          w_first_fail_nxt = '0;
          w_pass_nxt       = 1'b0;
        end
      end
      S_DRIVE: begin
        if (abort) begin
          w_state_nxt = S_IDLE;
          w_pass_nxt  = 1'b0;
        end else begin
          w_cnt_nxt   = CNT_W'(SETTLE_CYCLES);
          w_state_nxt = (SETTLE_CYCLES == 0) ? S_SAMPLE : S_SETTLE;
        end
      end
      S_SETTLE: begin
        if (abort) begin
          w_state_nxt = S_IDLE;
          w_pass_nxt  = 1'b0;
        end else if (r_cnt <= CNT_W'(1)) begin
          w_state_nxt = S_SAMPLE;
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      S_SAMPLE: begin
        if (abort) begin
          w_state_nxt = S_IDLE;
          w_pass_nxt  = 1'b0;
        end else begin
          if (w_mismatch) begin
            w_err_nxt = r_err + ERR_W'(1);
            if (!r_fail_valid) begin
              w_fail_valid_nxt = 1'b1;
              w_first_fail_nxt = r_idx;
            end
          end
          if (r_idx == IDX_W'(3)) begin
            w_state_nxt = S_DONE;
            w_pass_nxt  = (w_err_nxt == '0);
          end else begin
            w_idx_nxt   = r_idx + IDX_W'(1);
            w_state_nxt = S_DRIVE;
          end
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_busy_nxt = (w_state_nxt == S_DRIVE) || (w_state_nxt == S_SETTLE) ||
                      (w_state_nxt == S_SAMPLE);

  // Registered outputs; gate drive follows the vector being entered
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx        <= '0;
      r_cnt        <= '0;
      r_err        <= '0;
      r_fail_valid <= 1'b0;
      r_first_fail <= '0;
      r_pass       <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_gate_a     <= 1'b0;
      r_gate_b     <= 1'b0;
    end else begin
      r_idx        <= w_idx_nxt;
      r_cnt        <= w_cnt_nxt;
      r_err        <= w_err_nxt;
      r_fail_valid <= w_fail_valid_nxt;
      r_first_fail <= w_first_fail_nxt;
      r_pass       <= w_pass_nxt;
      r_busy       <= w_busy_nxt;
      r_done       <= (w_state_nxt == S_DONE);
      r_gate_a     <= w_busy_nxt & w_idx_nxt[1];
      r_gate_b     <= w_busy_nxt & w_idx_nxt[0];
    end
  end

  assign gate_a         = r_gate_a;
  assign gate_b         = r_gate_b;
  assign busy           = r_busy;
  assign done           = r_done;
  assign pass           = r_pass;
  assign err_count      = r_err;
  assign fail_valid     = r_fail_valid;
  assign first_fail_idx = r_first_fail;

endmodule

// File: doc/gate_sweep_ctrl.md
Name: gate_sweep_ctrl

Overview:
- Self-checking sequencer for a 2-input combinational gate (xor_df and siblings).
- On start, drives gate inputs {a,b} through 00, 01, 10, 11 in order.
- After each vector, waits a programmable settle time, samples the gate output and compares it against a parameterised truth table.
- Reports an error count, the first failing vector and pass/done; used as the on-chip replacement for manual truth-table benches.

Parameters:
- SETTLE_CYCLES, 2, cycles waited after driving a vector before sampling (0 allowed, max 15).
- TRUTH, 4'b0110, expected y per vector; bit index = {a,b} (default = XOR).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  begin a sweep; sampled only in IDLE.
- abort  input  1  cancel a sweep in progress.
- gate_a  output  1  registered drive to gate input a.
- gate_b  output  1  registered drive to gate input b.
- gate_y  input  1  gate output under test.
- busy  output  1  high in DRIVE/SETTLE/SAMPLE.
- done  output  1  one-cycle pulse on sweep completion.
- pass  output  1  1 iff last completed sweep had zero mismatches.
- err_count  output  3  mismatches in last/current sweep (0..4).
- fail_valid  output  1  at least one mismatch recorded.
- first_fail_idx  output  2  {a,b} of first mismatching vector.

Behaviour:
- Reset (asynchronous, immediate on rst_n=0):
  - state=IDLE, idx=0.
  - gate_a, gate_b, busy, done, pass, fail_valid = 0.
  - err_count=0, first_fail_idx=0.
- States: IDLE, DRIVE, SETTLE, SAMPLE, DONE. All outputs registered or Moore-decoded from state.
- IDLE:
  - gate_a/gate_b=0.
  - start=1 and abort=0 at an edge → DRIVE; idx=0; err_count, fail_valid, first_fail_idx and pass cleared.
  - start and abort both high → abort wins; stay IDLE.
- DRIVE:
  - {gate_a,gate_b}={idx[1],idx[0]}, held stable through DRIVE, SETTLE and SAMPLE.
  - Settle counter loaded with SETTLE_CYCLES.
  - Next state SETTLE, or SAMPLE directly if SETTLE_CYCLES=0.
- SETTLE: counter decrements each cycle; leaves after exactly SETTLE_CYCLES cycles → SAMPLE.
- SAMPLE:
  - gate_y compared with TRUTH[idx].
  - On mismatch: err_count+1. If fail_valid=0, first_fail_idx=idx and fail_valid=1 (first mismatch only, never overwritten within a sweep).
  - idx=3 → DONE; otherwise idx+1 → DRIVE. idx never wraps within a sweep.
- DONE:
  - done=1 for exactly one cycle.
  - pass=(err_count==0), including the final sample's result.
  - gate_a/gate_b return to 0. Next state IDLE.
- Timing:
  - Each vector costs SETTLE_CYCLES+2 cycles.
  - With start accepted at edge E0, done is high in the cycle following edge E0+4*(SETTLE_CYCLES+2). Default: E0+16.
- Hold: pass, err_count, fail_valid and first_fail_idx hold until the next accepted start or reset.
- start while busy or in DONE: ignored; no restart, no queuing.
- abort in DRIVE/SETTLE/SAMPLE:
  - Next edge → IDLE, gate_a/b=0, busy=0.
  - done not pulsed; pass forced 0.
  - err_count and first_fail_idx keep partial values.
- abort in IDLE/DONE: no effect; DONE still completes its pulse.
- rst_n low mid-sweep: immediate return to reset values; sweep lost. No done pulse after release until a new start.

Test Plan:
- Correct XOR model, SETTLE_CYCLES=2, start pulse at E0 → gate {a,b}=00,01,10,11, each held 4 cycles; done single pulse after E0+16; pass=1, err_count=0, fail_valid=0.
- OR gate substituted → err_count=1, fail_valid=1, first_fail_idx=3, pass=0, done still at E0+16.
- gate_y stuck at 0 → err_count=2, first_fail_idx=1, pass=0; stuck at 1 → err_count=2, first_fail_idx=0.
- abort asserted during SETTLE of vector 2 → IDLE next edge, gate_a=gate_b=0, no done pulse, pass=0; a new start then gives a full clean sweep with pass=1.
- start re-pulsed while busy, and start+abort together in IDLE → neither restarts; the original sweep's done timing is unchanged.
- SETTLE_CYCLES=0 build → done after E0+8; rst_n pulsed low mid-sweep → all outputs 0 immediately, busy=0, no done after release.
